// File: rtl/tx_symbol_sequencer_pkg.sv
// Shared types for the PAM-4 transmit sequencer: FSM states, 1s17 amplitude levels
// and the symbol-to-level map.
package tx_symbol_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  // Levels are the symmetric PAM-4 points -1, -1/3, +1/3, +1 in 1s17.
  localparam logic signed [17:0] LVL_M1 = 18'sh20000;
  localparam logic signed [17:0] LVL_M3 = -18'sd43691;
  localparam logic signed [17:0] LVL_P3 = 18'sd43690;
  localparam logic signed [17:0] LVL_P1 = 18'sd131071;

  function automatic logic signed [17:0] sym_to_level(input logic [1:0] sym);
    logic signed [17:0] lvl;
    case (sym)
      2'b00:   lvl = LVL_M1;
      2'b01:   lvl = LVL_M3;
      2'b10:   lvl = LVL_P3;
      default: lvl = LVL_P1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/tx_sym_mapper.sv
// Registered 2-bit symbol to 1s17 level map with zero insertion.
// Latency 1 clock; no backpressure, updates every cycle.
module tx_sym_mapper
  import tx_symbol_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               zero,
  input  logic [1:0]         sym,
  output logic signed [17:0] x
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
    end else if (zero) begin
      x <= '0;
    end else begin
      x <= sym_to_level(sym);
    end
  end

endmodule

// File: rtl/tx_symbol_sequencer.sv
// Burst framer feeding the PAM-4 shaping filter one zero-stuffed sample per clock; TX_PREAMBLE_EN adds a +1/-1 preamble.
// Latency: symbol handshake to x_out is 1 clock; FLUSH drains NTAPS zero samples before done.
// Backpressure: sym_ready pulses once per OSR cycles in DATA only; a missed slot sends zeros and sets underrun.
module tx_symbol_sequencer
  import tx_symbol_sequencer_pkg::*;
#(
  parameter int OSR     = 4,
  parameter int NTAPS   = 21,
  parameter int PRE_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         sym_in,
  input  logic               sym_valid,
  input  logic               sym_last,
  output logic               sym_ready,
  output logic signed [17:0] x_out,
  output logic               filt_clr,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  localparam int PHW = $clog2(OSR);
  localparam int FCW = $clog2(NTAPS + 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(OSR - 1);
  localparam logic [FCW-1:0] FC_INIT = FCW'(NTAPS - 1);

  state_t         state;
  logic [PHW-1:0] ph;
  logic [FCW-1:0] fcnt;
  logic           last_q;
  logic           hs;
  logic           map_zero;
  logic [1:0]     map_sym;

`ifdef TX_PREAMBLE_EN
  localparam int PCW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRE_LEN - 1);
  logic [PCW-1:0] pcnt;
`else
  // PRE_LEN only matters with the preamble compiled in.
  if (PRE_LEN < 0) begin : g_pre_len_unused
  end
`endif

  assign hs = sym_valid & sym_ready;

  always_comb begin
    map_zero = 1'b1;
    map_sym  = 2'b00;
    case (state)
      DATA: begin
        map_zero = !hs;
        map_sym  = sym_in;
      end
`ifdef TX_PREAMBLE_EN
      PREAMBLE: begin
        map_zero = (ph != '0);
        map_sym  = pcnt[0] ? 2'b00 : 2'b11;
      end
`endif
      default: ;
    endcase
  end

  tx_sym_mapper u_mapper (
    .clk   (clk),
    .reset (reset),
    .zero  (map_zero),
    .sym   (map_sym),
    .x     (x_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ph        <= '0;
      fcnt      <= '0;
      last_q    <= 1'b0;
      sym_ready <= 1'b0;
      filt_clr  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
`ifdef TX_PREAMBLE_EN
      pcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            underrun <= 1'b0;
            ph       <= '0;
            last_q   <= 1'b0;
            filt_clr <= 1'b0;
            busy     <= 1'b1;
`ifdef TX_PREAMBLE_EN
            pcnt     <= '0;
            state    <= PREAMBLE;
`else
            sym_ready <= 1'b1;
            state     <= DATA;
`endif
          end
        end
`ifdef TX_PREAMBLE_EN
        PREAMBLE: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            if (pcnt == PC_LAST) begin
              sym_ready <= 1'b1;
              state     <= DATA;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
`endif
        DATA: begin
          // sym_ready is registered so it is high exactly while ph == 0.
          if (ph == '0) begin
            if (hs) begin
              last_q <= sym_last;
            end else begin
              underrun <= 1'b1;
            end
          end
          if (ph == PH_LAST) begin
            ph <= '0;
            if (last_q) begin
              sym_ready <= 1'b0;
              fcnt      <= FC_INIT;
              done      <= (NTAPS == 1);
              state     <= FLUSH;
            end else begin
              sym_ready <= 1'b1;
            end
          end else begin
            ph        <= ph + 1'b1;
            sym_ready <= 1'b0;
          end
        end
        FLUSH: begin
          // done is raised while the counter sits at 0, so busy drops one cycle later.
          if (fcnt == '0) begin
            busy     <= 1'b0;
            filt_clr <= 1'b1;
            last_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            fcnt <= fcnt - 1'b1;
            done <= (fcnt == FCW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_symbol_sequencer.sv
// Directed bench for tx_symbol_sequencer; expected sample streams are built per burst
// from the framing rules and checked every cycle, with a few literal pins.
module tb_tx_symbol_sequencer;

  localparam int OSR   = 4;
  localparam int NTAPS = 21;
`ifdef TX_PREAMBLE_EN
  localparam int PRE    = 8;
  localparam int DONE_A = 68;
`else
  localparam int PRE    = 0;
  localparam int DONE_A = 36;
`endif
  localparam int D0 = PRE * OSR;

  logic               clk;
  logic               reset;
  logic               start;
  logic [1:0]         sym_in;
  logic               sym_valid;
  logic               sym_last;
  logic               sym_ready;
  logic signed [17:0] x_out;
  logic               filt_clr;
  logic               busy;
  logic               done;
  logic               underrun;

  tx_symbol_sequencer #(.OSR(OSR), .NTAPS(NTAPS), .PRE_LEN(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_last  (sym_last),
    .sym_ready (sym_ready),
    .x_out     (x_out),
    .filt_clr  (filt_clr),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    bit rdy;
    bit busy;
    bit clr;
    bit done;
    bit und;
  } exp_t;

  exp_t eq[$];
  bit   exp_und_idle;
  bit   chk_en;
  int   nvec;
  int   nerr;
  int   cyc;
  int   slots[$];
  int   xcap[0:127];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
    end
  endtask

  function automatic int lvl(input int s);
    case (s)
      0:       return -131072;
      1:       return -43691;
      2:       return 43690;
      default: return 131071;
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_x_out"},     x_out,     0);
    chk({tag, "_sym_ready"}, sym_ready, 0);
    chk({tag, "_filt_clr"},  filt_clr,  1);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_underrun"},  underrun,  0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (eq.size() > 0) begin
        e = eq.pop_front();
      end else begin
        e.x = 0; e.rdy = 0; e.busy = 0; e.clr = 1; e.done = 0; e.und = exp_und_idle;
      end
      chk("x_out",     x_out,     e.x);
      chk("sym_ready", sym_ready, int'(e.rdy));
      chk("busy",      busy,      int'(e.busy));
      chk("filt_clr",  filt_clr,  int'(e.clr));
      chk("done",      done,      int'(e.done));
      chk("underrun",  underrun,  int'(e.und));
    end
  end

  // Runs one burst of the symbols in slots (negative entry = withheld slot).
  task automatic run_burst(input int abort_at, input int extra_start,
                           output int nhs, output int dcnt, output int dcyc,
                           output int rfirst, output int rlast);
    int   smp[$];
    int   s, l, j, gapc;
    exp_t e;
    gapc = -1;
    for (int p = 0; p < PRE; p++) begin
      smp.push_back((p % 2 == 0) ? 131071 : -131072);
      for (int z = 1; z < OSR; z++) smp.push_back(0);
    end
    for (int i = 0; i < slots.size(); i++) begin
      smp.push_back(slots[i] < 0 ? 0 : lvl(slots[i]));
      if (slots[i] < 0 && gapc < 0) gapc = D0 + i * OSR;
      for (int z = 1; z < OSR; z++) smp.push_back(0);
    end
    s = smp.size();
    l = s + NTAPS;
    nhs = 0; dcnt = 0; dcyc = -1; rfirst = -1; rlast = -1; j = 0;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < l; k++) begin
      e.x    = (k >= 1 && k <= s) ? smp[k-1] : 0;
      e.rdy  = (k >= D0 && k < s && (k - D0) % OSR == 0);
      e.busy = 1'b1;
      e.clr  = 1'b0;
      e.done = (k == l - 1);
      e.und  = (gapc >= 0 && k > gapc);
      eq.push_back(e);
    end
    exp_und_idle = (gapc >= 0);
    #1 start = 1'b0;

    for (int k = 0; k < l + 3; k++) begin
      @(negedge clk);
      if (k < 128) xcap[k] = x_out;
      if (done) begin
        dcnt++;
        dcyc = k;
      end
      start = (k == extra_start);
      if (sym_ready) begin
        if (rfirst < 0) rfirst = k;
        rlast = k;
        if (j < slots.size()) begin
          sym_valid = (slots[j] >= 0);
          sym_in    = (slots[j] >= 0) ? 2'(slots[j]) : 2'b11;
          sym_last  = (j == slots.size() - 1);
          j++;
        end else begin
          sym_valid = 1'b0;
        end
      end else begin
        sym_valid = 1'b1;
        sym_in    = 2'($urandom_range(3));
        sym_last  = 1'b1;
      end
      if (sym_ready && sym_valid) nhs++;
      if (k == abort_at) begin
        #2 reset = 1'b0;
        eq.delete();
        exp_und_idle = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        #2 reset = 1'b1;
        break;
      end
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    int nhs, dcnt, dcyc, rf, rl;
    nvec = 0; nerr = 0; cyc = 0;
    chk_en = 1'b0; exp_und_idle = 1'b0;
    reset = 1'b0; start = 1'b0; sym_in = 2'b00; sym_valid = 1'b0; sym_last = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single burst 11,00,10,01.
    slots = {3, 0, 2, 1};
    run_burst(-1, -1, nhs, dcnt, dcyc, rf, rl);
    chk("A_sym0", xcap[D0+1], 131071);
    chk("A_sym1", xcap[D0+5], -131072);
    chk("A_sym2", xcap[D0+9], 43690);
    chk("A_sym3", xcap[D0+13], -43691);
    chk("A_zero", xcap[D0+14], 0);
    chk("A_done_cnt", dcnt, 1);
    chk("A_done_cyc", dcyc, DONE_A);
    chk("A_hs", nhs, 4);
`ifdef TX_PREAMBLE_EN
    chk("P_pre0", xcap[1], 131071);
    chk("P_pre1", xcap[5], -131072);
    chk("P_pre7", xcap[29], -131072);
`endif

    // Underrun in slot 2, plus a start pulse during FLUSH.
    slots = {1, 2, -1, 3, 0};
    run_burst(-1, D0 + 5 * OSR + 5, nhs, dcnt, dcyc, rf, rl);
    chk("U_gap", xcap[D0+9], 0);
    chk("U_sym3", xcap[D0+13], 131071);
    chk("U_done_cnt", dcnt, 1);
    chk("U_hs", nhs, 4);
    chk("U_sticky", underrun, 1);
    chk("U_idle", busy, 0);

    // Back-to-back: valid held high for 10 symbols.
    slots = {0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    run_burst(-1, -1, nhs, dcnt, dcyc, rf, rl);
    chk("B_hs", nhs, 10);
    chk("B_span", rl - rf, 36);
    chk("B_und_clr", underrun, 0);

    // Reset dropped mid-DATA at ph=2.
    slots = {2, 2, 2, 2};
    run_burst(D0 + 2, -1, nhs, dcnt, dcyc, rf, rl);
    chk("R_no_done", dcnt, 0);

    // Fresh burst after the reset.
    slots = {0, 3};
    run_burst(-1, -1, nhs, dcnt, dcyc, rf, rl);
    chk("N_sym1", xcap[D0+5], 131071);
    chk("N_done_cnt", dcnt, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tx_symbol_sequencer.md
Name: tx_symbol_sequencer

Overview:
Feeds the 21-tap 4-ary PAM transmit pulse-shaping filter, one 18-bit sample per clock. Accepts 2-bit symbols over a valid/ready handshake and maps them to 1s17 amplitude levels. Zero-stuffs each symbol by OSR and frames each burst as IDLE -> (PREAMBLE) -> DATA -> FLUSH so the filter drains cleanly. Also drives the filter's clear and reports burst status.

Parameters:
OSR, 4, samples per symbol (zero-stuffing factor); >= 2
NTAPS, 21, filter length; FLUSH emits NTAPS zero samples
PRE_LEN, 8, preamble length in symbols (used only when TX_PREAMBLE_EN is defined)

Ports:
clk  in  1  system clock; one filter sample per cycle
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a burst when in IDLE, ignored otherwise
sym_in  in  2  symbol: 00=-1, 01=-1/3, 10=+1/3, 11=+1
sym_valid  in  1  sym_in valid
sym_last  in  1  qualifies sym_in as the final symbol of the burst
sym_ready  out  1  sequencer accepts sym_in this cycle
x_out  out  18 signed  1s17 sample to the filter x_in
filt_clr  out  1  active-high clear to the filter; high in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when FLUSH completes
underrun  out  1  sticky; set when DATA needs a symbol and none is valid; cleared by start

Behaviour:
- Reset values (async, reset low): state=IDLE, x_out=0, sym_ready=0, filt_clr=1, busy=0, done=0, underrun=0, phase counter=0, flush counter=0. All outputs are registered.
- Level map (constants): 00->-18'sd131072, 01->-18'sd43691, 10->18'sd43690, 11->18'sd131071.
- Phase counter ph counts 0..OSR-1 in PREAMBLE and DATA and wraps to 0. On ph=0, x_out is the symbol level; otherwise x_out=0.
- IDLE: x_out=0, filt_clr=1. On start: clear underrun, set ph=0, go to PREAMBLE if TX_PREAMBLE_EN is defined, else DATA. filt_clr deasserts in the same cycle the state leaves IDLE.
- PREAMBLE: emits PRE_LEN symbols alternating +1, -1, starting with +1, at OSR spacing. After the last preamble symbol's OSR-1 zero phase, go to DATA with ph=0.
- DATA:
  - sym_ready is asserted combinationally-equivalent (registered one cycle ahead) in the cycle where the next x_out will be the ph=0 sample.
  - A handshake is sym_valid & sym_ready, and exactly one symbol is taken per OSR cycles.
  - The accepted symbol's level appears on x_out in the next cycle; handshake-to-x_out latency is 1 clock.
  - If sym_valid=0 at the handshake slot: emit 0 for that symbol period, set underrun, stay in DATA.
  - Accepting a symbol with sym_last=1: finish its OSR-1 zero samples, then go to FLUSH.
- FLUSH: x_out=0 for NTAPS cycles, with the counter counting NTAPS-1 down to 0. At 0, pulse done for one cycle and go to IDLE.
- start while busy: ignored, with no effect on state or underrun.
- sym_valid outside the DATA handshake slot: ignored; sym_ready stays 0.
- reset asserted mid-burst: immediate return to reset values. Any partially sent symbol is dropped and no done pulse is produced.
- Widths: x_out keeps 18 bits; no arithmetic beyond the counters. ph width is clog2(OSR); the flush counter width is clog2(NTAPS+1).

Optional Feature:
- TX_PREAMBLE_EN defined: PREAMBLE state present; each burst starts with PRE_LEN alternating ±1 symbols before DATA.
- Not defined: the PREAMBLE state and its counter are omitted, start goes directly to DATA, and PRE_LEN is unused.

Decomposition:
- Shared package holds:
  - state enum (IDLE, PREAMBLE, DATA, FLUSH)
  - the four 18-bit level constants LVL_M1, LVL_M3, LVL_P3, LVL_P1
  - a symbol-to-level function
- One natural sub-module: tx_sym_mapper, a registered 2-bit-to-18-bit level map with zero-insert control. The top keeps the FSM, counters and handshake.

Test Plan:
- Reset mid-DATA: drop reset for 1 cycle at ph=2 -> all outputs at reset values immediately; a new start works normally.
- Single burst, macro off, OSR=4, symbols 11,00,10,01 (last on 01):
  - x_out = 131071,0,0,0,-131072,0,0,0,43690,0,0,0,-43691,0,0,0.
  - Then 21 zeros, done pulse, and busy falls on the cycle after done.
- Underrun: withhold sym_valid for one slot mid-burst -> 4 zero samples, underrun=1 and stays 1 through done; next start clears it.
- Macro on, PRE_LEN=8: start -> x_out = 131071,0,0,0,-131072,0,0,0 repeated 4 times, then the first data symbol at cycle 33 after start.
- start pulsed during FLUSH -> ignored, done occurs exactly once, and the state returns to IDLE.
- Back-to-back: sym_valid held high for 10 symbols -> sym_ready high exactly once per 4 cycles, and 10 handshakes occur in 40 cycles.
